// File: rtl/ps2_device_tx_if.sv
// Byte stream port of the PS/2 device transmitter: valid/ready push of scan codes.
interface ps2_device_tx_if;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: FIFO-buffered scan codes serialized as 11-bit frames.
// Define PS2_TX_BREAK_EN to send every byte as make/release: b, 0xF0, b.
module ps2_device_tx #(
    parameter int unsigned CLK_DIV    = 2500,
    parameter int unsigned GAP_CYCLES = 5000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic           clk,
    input  logic           clrn,
    ps2_device_tx_if.slave bus,
    input  logic           host_inhibit,
    output logic           ps2_clk,
    output logic           ps2_data,
    output logic           busy
);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [AW:0]   FULL_FILL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, BIT_H, BIT_L, GAP, INHIBIT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    idx, idx_n;
    logic          resend, resend_n;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, fill_n;
    logic          push, pop, empty;
    logic [7:0]    head, tx_byte;
    logic [10:0]   frame;
    logic          clk_n, data_n;

`ifdef PS2_TX_BREAK_EN
    logic [1:0]    sub, sub_n;
`endif

    assign empty = (wr_ptr == rd_ptr);
    assign push  = bus.din_valid & bus.din_ready;
    assign head  = mem[rd_ptr[AW-1:0]];

`ifdef PS2_TX_BREAK_EN
    assign tx_byte = (sub == 2'd1) ? 8'hF0 : head;
`else
    assign tx_byte = head;
`endif

    assign frame = {1'b1, ~^tx_byte, tx_byte, 1'b0};

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        idx_n    = idx;
        resend_n = resend;
        pop      = 1'b0;
`ifdef PS2_TX_BREAK_EN
        sub_n    = sub;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!empty && !host_inhibit) begin
                    state_n = BIT_H;
                    idx_n   = '0;
                end
            end
            BIT_H: begin
                if (host_inhibit)
                    state_n = INHIBIT;
                else if (cnt == HALF_LAST)
                    state_n = BIT_L;
            end
            BIT_L: begin
                if (host_inhibit) begin
                    state_n = INHIBIT;
                end else if (cnt == HALF_LAST) begin
                    if (idx == 4'd10) begin
                        state_n = GAP;
                    end else begin
                        idx_n   = idx + 4'd1;
                        state_n = BIT_H;
                    end
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = IDLE;
                    // A gap that follows an aborted frame leaves the head in place for resend.
                    if (resend) begin
                        resend_n = 1'b0;
                    end else begin
`ifdef PS2_TX_BREAK_EN
                        if (sub == 2'd2) begin
                            pop   = 1'b1;
                            sub_n = 2'd0;
                        end else begin
                            sub_n = sub + 2'd1;
                        end
`else
                        pop = 1'b1;
`endif
                    end
                end
            end
            INHIBIT: begin
                cnt_n = '0;
                if (!host_inhibit) begin
                    state_n  = GAP;
                    resend_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (state_n != state)
            cnt_n = '0;
    end

    assign wr_ptr_n = wr_ptr + (AW + 1)'(push);
    assign rd_ptr_n = rd_ptr + (AW + 1)'(pop);
    assign fill_n   = wr_ptr_n - rd_ptr_n;

    // Line levels are decoded from the next state so they switch on the same edge as the FSM.
    always_comb begin
        clk_n  = (state_n != BIT_L);
        data_n = 1'b1;
        if (state_n == BIT_H || state_n == BIT_L)
            data_n = frame[idx_n];
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            resend        <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            ps2_clk       <= 1'b1;
            ps2_data      <= 1'b1;
            bus.din_ready <= 1'b1;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            idx           <= idx_n;
            resend        <= resend_n;
            wr_ptr        <= wr_ptr_n;
            rd_ptr        <= rd_ptr_n;
            ps2_clk       <= clk_n;
            ps2_data      <= data_n;
            bus.din_ready <= (fill_n != FULL_FILL);
            busy          <= (state_n != IDLE) || (wr_ptr_n != rd_ptr_n);
        end
    end

`ifdef PS2_TX_BREAK_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            sub <= 2'd0;
        else
            sub <= sub_n;
    end
`endif

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= bus.din;
    end
endmodule

// File: tb/tb_ps2_device_tx.sv
// Self-checking bench for ps2_device_tx: timeline model of the PS/2 line waveform plus directed tests.
module tb_ps2_device_tx;
    localparam int CD    = 4;
    localparam int GAP   = 8;
    localparam int DEPTH = 8;
    localparam int FRAME = 22 * CD;

    logic clk = 1'b0;
    logic clrn = 1'b0;
    logic host_inhibit = 1'b0;
    logic ps2_clk, ps2_data, busy;

    ps2_device_tx_if bus();

    ps2_device_tx #(.CLK_DIV(CD), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .clrn(clrn),
        .bus(bus),
        .host_inhibit(host_inhibit),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    // Model: pending frame bytes, and where on the timeline the link currently is.
    typedef enum {M_IDLE, M_FRAME, M_INH, M_GAP} mmode_t;
    mmode_t      mode = M_IDLE;
    logic [7:0]  q[$];
    int          t = 0;
    int          gap_left = 0;
    bit          must_start = 0;
    int          cyc = 0;
    int          start_cyc[$];
    int          first_fall[$];
    logic [10:0] rx[$];
    logic [10:0] rbuf = '0;
    int          nbits = 0;
    logic        prev_clk = 1'b1;

    always @(negedge clk) begin
        logic        exp_clk, exp_data, accept;
        logic [10:0] fr;
        logic [7:0]  in_byte;
        int          half;
        cyc++;
        if (!clrn) begin
            q.delete();
            mode = M_IDLE;
            must_start = 0;
            nbits = 0;
            check("rst_ps2_clk", ps2_clk, 1);
            check("rst_ps2_data", ps2_data, 1);
            check("rst_din_ready", bus.din_ready, 1);
            check("rst_busy", busy, 0);
            prev_clk = 1'b1;
        end else begin
            if (mode == M_IDLE) begin
                check("start_timing", !ps2_data, must_start);
                if (!ps2_data && q.size() != 0) begin
                    mode = M_FRAME;
                    t = 0;
                    nbits = 0;
                    start_cyc.push_back(cyc);
                end
            end
            must_start = 0;

            exp_clk = 1'b1;
            exp_data = 1'b1;
            if (mode == M_FRAME && t < FRAME) begin
                half = t / CD;
                fr = frame_of(q[0]);
                exp_clk = (half % 2 == 0);
                exp_data = fr[half / 2];
            end
            check("ps2_clk", ps2_clk, exp_clk);
            check("ps2_data", ps2_data, exp_data);
            check("busy", busy, q.size() != 0);
            check("din_ready", bus.din_ready, q.size() < DEPTH);

            if (prev_clk && !ps2_clk && nbits < 11) begin
                if (nbits == 0) first_fall.push_back(cyc);
                rbuf[nbits] = ps2_data;
                nbits++;
                if (nbits == 11) rx.push_back(rbuf);
            end
            prev_clk = ps2_clk;

            accept = bus.din_valid && (q.size() < DEPTH);
            in_byte = bus.din;
            case (mode)
                M_IDLE: must_start = (q.size() != 0) && !host_inhibit;
                M_FRAME: begin
                    if (t < FRAME && host_inhibit) begin
                        mode = M_INH;
                    end else begin
                        t++;
                        if (t == FRAME + GAP) begin
                            void'(q.pop_front());
                            mode = M_IDLE;
                        end
                    end
                end
                M_INH: if (!host_inhibit) begin
                    mode = M_GAP;
                    gap_left = GAP;
                end
                M_GAP: begin
                    gap_left--;
                    if (gap_left == 0) mode = M_IDLE;
                end
                default: mode = M_IDLE;
            endcase
            if (accept) q.push_back(in_byte);
        end
    end

    task automatic push(input logic [7:0] b);
        @(posedge clk); #1;
        bus.din_valid = 1'b1;
        bus.din = b;
        @(posedge clk); #1;
        bus.din_valid = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        repeat (3) @(posedge clk);
        #1;
        while ((busy || mode != M_IDLE) && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", n < maxc, 1);
    endtask

    task automatic wait_bits(input int nb, input int maxc);
        int n = 0;
        while (!(mode == M_FRAME && nbits == nb) && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        check("bit_wait_timeout", n < maxc, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        bus.din_valid = 1'b0;
        bus.din = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_lines", {ps2_clk, ps2_data}, 2'b11);
        check("reset_ready_busy", {bus.din_ready, busy}, 2'b10);
        clrn = 1'b1;

        // Single frame with known bit pattern, then two back-to-back frames.
        push(8'h1C);
        wait_idle(400);
        check("rx_count_1", rx.size(), 1);
        check("frame_1C", rx[0], 11'h438);
        check("first_fall_delay", first_fall[0] - start_cyc[0], CD);
        push(8'h00);
        push(8'hFF);
        wait_idle(600);
        check("rx_count_3", rx.size(), 3);
        check("frame_00", rx[1], 11'h600);
        check("frame_FF", rx[2], 11'h7FE);
        check("frame_period", start_cyc[2] - start_cyc[1], 97);

        // Fill the FIFO while the host inhibits; the ninth byte must be dropped.
        @(posedge clk); #1;
        host_inhibit = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.din_valid = 1'b1;
            bus.din = 8'h10 + 8'(i);
            @(posedge clk); #1;
        end
        bus.din_valid = 1'b0;
        @(posedge clk); #1;
        check("full_ready_low", bus.din_ready, 0);
        check("full_busy", busy, 1);
        host_inhibit = 1'b0;
        wait_idle(2000);
        check("rx_count_11", rx.size(), 11);
        for (int i = 0; i < 8; i++)
            check("fifo_order", rx[3 + i][8:1], 8'h10 + 8'(i));
        check("busy_after_drain", busy, 0);

        // Abort during BIT_L of bit 5, then a full resend.
        push(8'hA5);
        wait_bits(6, 400);
        host_inhibit = 1'b1;
        @(posedge clk); #1;
        check("abort_lines", {ps2_clk, ps2_data}, 2'b11);
        repeat (10) @(posedge clk);
        #1;
        host_inhibit = 1'b0;
        wait_idle(600);
        check("rx_count_12", rx.size(), 12);
        check("frame_A5_resent", rx[11], 11'h74A);

        // Asynchronous reset mid-frame, then a clean frame.
        push(8'h3C);
        wait_bits(4, 400);
        #2;
        clrn = 1'b0;
        #1;
        check("async_rst_lines", {ps2_clk, ps2_data}, 2'b11);
        check("async_rst_ready_busy", {bus.din_ready, busy}, 2'b10);
        repeat (2) @(posedge clk);
        #3;
        clrn = 1'b1;
        push(8'h5A);
        wait_idle(400);
        check("rx_count_13", rx.size(), 13);
        check("frame_5A", rx[12], 11'h6B4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_device_tx.md
# ps2_device_tx

PS/2 device-side transmitter: accepts scan-code bytes on a valid/ready port, buffers them in a FIFO and serializes each one as an 11-bit PS/2 frame on generated `ps2_clk`/`ps2_data` lines. It is the keyboard end of the link, driving the existing `ps2_keyboard` host receiver in simulation and in loopback on the board. The generated clock is divided from the system clock.

## Interface
- `CLK_DIV`, 2500: system cycles per PS/2 clock half-period, ≥2 (50 MHz gives 10 kHz).
- `GAP_CYCLES`, 5000: idle cycles, both lines high, after every frame, ≥1.
- `FIFO_DEPTH`, 8: byte FIFO entries, power of two, ≥2.

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `clrn` in 1: reset, asynchronous, active-low.
- `din` in 8: scan-code byte.
- `din_valid` in 1: `din` is valid this cycle.
- `din_ready` out 1: FIFO not full. Push when `din_valid & din_ready`.
- `host_inhibit` in 1: host pulls clock low. Abort or hold transmission.
- `ps2_clk` out 1: generated PS/2 clock, idle high.
- `ps2_data` out 1: PS/2 data, idle high.
- `busy` out 1: frame in progress or FIFO non-empty.

## Operation
- Frame layout, sent in this order: start 0, d[0]..d[7] LSB first, odd parity (`~^d`), stop 1.
- FSM states: IDLE, BIT_H, BIT_L, GAP, INHIBIT.
- IDLE → BIT_H when the FIFO is non-empty and `host_inhibit`=0. The head byte is peeked, not popped. Bit index starts at 0.
- BIT_H: `ps2_clk`=1 and `ps2_data`=frame bit[idx] for `CLK_DIV` cycles, then → BIT_L.
- BIT_L: `ps2_clk`=0 and `ps2_data` is held for `CLK_DIV` cycles. The host samples on the falling edge.
  - If idx<10: idx+1 and → BIT_H.
  - If idx=10: → GAP.
- GAP: both lines high for `GAP_CYCLES`. The frame is then complete. Pop the FIFO (see Configuration), then → IDLE.
- `host_inhibit`=1 in BIT_H or BIT_L:
  - Abort on the next edge and drive both lines to 1.
  - → INHIBIT. The byte is not popped.
- INHIBIT → GAP once `host_inhibit`=0. That GAP does not pop the FIFO. The aborted frame is then resent from the start bit.
- `host_inhibit` in IDLE blocks frame start. In GAP it has no effect.
- FIFO:
  - `din_ready` is registered and equals !full.
  - Push and pop in the same cycle are both honoured.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - A push while full is ignored (cannot occur while obeying `din_ready`).
- Half-period counter: width $clog2(max(CLK_DIV, GAP_CYCLES)). It reloads on every state change.

## Timing
- Reset values: `ps2_clk`=1, `ps2_data`=1, `din_ready`=1, `busy`=0, FSM=IDLE, FIFO empty, counters 0.
- Reset asserted mid-frame: lines go high immediately (asynchronous) and FIFO contents are lost.
- All outputs are registered, with no combinational path from inputs to outputs.
- A push into an empty idle block drives `ps2_data`=0 (start bit) 2 cycles later, with `ps2_clk` still high.
- First falling edge of `ps2_clk`: `CLK_DIV` cycles after the start bit appears.
- Frame period: 22·`CLK_DIV` + `GAP_CYCLES` cycles (+1 IDLE cycle).
- `ps2_data` changes only on the cycle `ps2_clk` rises, or at frame start. It is stable for ≥`CLK_DIV` cycles around every falling edge.
- `busy` rises the cycle after the first push and falls the cycle after the final pop leaves the FIFO empty in IDLE.

## Configuration
- `PS2_TX_BREAK_EN` defined: every FIFO byte b sends three frames, b, 0xF0, b (make then release), each followed by GAP.
  - A 2-bit sub-index selects the frame.
  - The FIFO pops only after the third frame's GAP.
  - An inhibit resends only the aborted sub-frame.
- `PS2_TX_BREAK_EN` undefined: one frame per byte, with no sub-index logic.

## Test plan
- `CLK_DIV`=4, `GAP_CYCLES`=8, push 0x1C → bits at the 11 `ps2_clk` falling edges are 0,0,0,1,1,1,0,0,0,0,1 (parity 0). Next frame starts at ≥96 cycles.
- Push 0x00 → parity bit is 1. Push 0xFF → parity bit is 1. Stop bit is 1 in both.
- Hold `host_inhibit`=1 and push 9 bytes → `din_ready` is 0 after the 8th; the 9th is ignored. Release inhibit → 8 frames go out in push order and `busy` falls after the last.
- Raise `host_inhibit` during BIT_L of idx 5 → both lines are 1 next cycle. Release → GAP, then a complete resend of the same byte, with no byte lost or duplicated.
- Loopback into `ps2_keyboard` with random bytes → receiver `data` matches the sequence and `overflow` stays 0. With `PS2_TX_BREAK_EN`, 0x1C yields 1C, F0, 1C.
- Drop `clrn` mid-frame at bit 3 → lines are high immediately, `din_ready`=1 and `busy`=0. After release, a new push transmits cleanly.
